// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronizes RXD, validates the start bit, samples each
// bit at its centre on the oversampling tick and presents the byte with status.
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       TICK,
  input  logic       RXD,
  input  logic       PAR_EN,
  input  logic       PAR_ODD,
  input  logic       RD,
  output logic [7:0] DOUT,
  output logic       RDY,
  output logic       FE,
  output logic       PE,
  output logic       OE,
  output logic       BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BRK    = 3'd5;

  logic                 rxd_p0;
  logic                 rxd_p1;
  logic                 rxd_s;
  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic                 par_en_l;
  logic                 par_odd_l;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 tick_en;
  logic                 start_smp;
  logic                 bit_end;
  logic                 done;
  logic                 accept;

  function automatic logic parity_err(input logic [DATA_BITS-1:0] d,
                                      input logic                 p,
                                      input logic                 odd);
    return (^d) ^ p ^ odd;
  endfunction

  assign rxd_s     = rxd_p1;
  assign tick_en   = CE & TICK;
  assign start_smp = (state == S_START) && tick_en && (tick_cnt == TICK_HALF);
  assign bit_end   = tick_en && (tick_cnt == TICK_LAST);
  assign done      = (state == S_STOP) && bit_end;
  assign accept    = !RDY || RD;

  // stage p0/p1: RXD synchronizer, idles high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_p1 <= rxd_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!CE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (!rxd_s) state_nxt = S_START;
        S_START:  if (start_smp) state_nxt = rxd_s ? S_IDLE : S_DATA;
        S_DATA:   if (bit_end && (bit_cnt == BIT_LAST))
                    state_nxt = par_en_l ? S_PARITY : S_STOP;
        S_PARITY: if (bit_end) state_nxt = S_STOP;
        S_STOP:   if (bit_end) state_nxt = rxd_s ? S_IDLE : S_BRK;
        S_BRK:    if (rxd_s) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != S_IDLE);
    end
  end

  // Tick counter restarts at every sample point so the next one lands a full bit later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
    end else if (!CE || (state == S_IDLE) || (state == S_BRK) || start_smp || bit_end) begin
      tick_cnt <= '0;
    end else if (tick_en) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt <= '0;
    end else if (!CE || (state != S_DATA)) begin
      bit_cnt <= '0;
    end else if (bit_end) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
    end else if (state == S_IDLE) begin
      par_en_l  <= PAR_EN;
      par_odd_l <= PAR_ODD;
    end
  end

  // stage p2: bit assembly, LSB arrives first and ends at bit 0
  always_ff @(posedge CLK) begin
    if ((state == S_DATA) && bit_end) begin
      shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
    end
    if ((state == S_PARITY) && bit_end) begin
      par_err <= parity_err(shreg, rxd_s, par_odd_l);
    end
  end

  // Host side: a frame finishing while an unread byte is held is dropped as overrun.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOUT <= 8'h00;
      RDY  <= 1'b0;
      FE   <= 1'b0;
      PE   <= 1'b0;
      OE   <= 1'b0;
    end else if (done) begin
      if (accept) begin
        DOUT <= 8'(shreg);
        RDY  <= 1'b1;
        FE   <= !rxd_s;
        PE   <= par_en_l & par_err;
        OE   <= 1'b0;
      end else begin
        OE   <= 1'b1;
      end
    end else if (RD) begin
      RDY <= 1'b0;
      FE  <= 1'b0;
      PE  <= 1'b0;
      OE  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frame-level reference model of the host-side status,
// directed scenarios followed by randomized frames.
module tb_uart_rx_frame;
  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int TP     = 4;
  localparam int BITCLK = OS * TP;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CE;
  logic       TICK;
  logic       RXD;
  logic       PAR_EN;
  logic       PAR_ODD;
  logic       RD;
  logic [7:0] DOUT;
  logic       RDY;
  logic       FE;
  logic       PE;
  logic       OE;
  logic       BUSY;

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  int m_dout, m_rdy, m_fe, m_pe, m_oe;

  uart_rx_frame #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .TICK(TICK), .RXD(RXD),
    .PAR_EN(PAR_EN), .PAR_ODD(PAR_ODD), .RD(RD),
    .DOUT(DOUT), .RDY(RDY), .FE(FE), .PE(PE), .OE(OE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // TICK is high for one CLK every TP cycles, sampled on posedges with index%TP==1.
  initial begin
    TICK = 1'b0;
    forever begin
      @(negedge CLK);
      TICK = (cyc % TP == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_dout"}, int'(DOUT), m_dout);
    check_eq({tag, "_rdy"},  int'(RDY),  m_rdy);
    check_eq({tag, "_fe"},   int'(FE),   m_fe);
    check_eq({tag, "_pe"},   int'(PE),   m_pe);
    check_eq({tag, "_oe"},   int'(OE),   m_oe);
  endtask

  task automatic model_reset();
    m_dout = 0; m_rdy = 0; m_fe = 0; m_pe = 0; m_oe = 0;
  endtask

  task automatic align();
    while (cyc % TP != 1) @(negedge CLK);
  endtask

  // Whole frame; completion expected one edge after the stop-centre tick.
  task automatic send_frame(input string tag, input logic [7:0] data, input logic pen,
                            input logic podd, input logic pbit, input logic stop,
                            input logic rd_done);
    int nb, done_off;
    logic [15:0] bits;
    logic perr;
    nb = 1 + DB + (pen ? 1 : 0) + 1;
    bits = '0;
    for (int i = 0; i < DB; i++) bits[1 + i] = data[i];
    if (pen) bits[1 + DB] = pbit;
    bits[nb - 1] = stop;
    done_off = TP * (OS / 2 + OS * (nb - 1));
    perr = pen ? ((^data) ^ pbit ^ podd) : 1'b0;
    align();
    PAR_EN  = pen;
    PAR_ODD = podd;
    for (int n = 0; n < nb * BITCLK; n++) begin
      if (n % BITCLK == 0) RXD = bits[n / BITCLK];
      if (n == 2) check_eq({tag, "_busy_pre"}, int'(BUSY), 0);
      if (n == 3) check_eq({tag, "_busy"}, int'(BUSY), 1);
      if (n == 100) begin
        PAR_EN  = ($urandom % 2) == 1;
        PAR_ODD = ($urandom % 2) == 1;
      end
      if (n == done_off - 1) begin
        check_eq({tag, "_rdy_early"}, int'(RDY), m_rdy);
        if (rd_done) RD = 1'b1;
      end
      if (n == done_off) begin
        RD = 1'b0;
        if (m_rdy == 0 || rd_done) begin
          m_dout = int'(data);
          m_rdy  = 1;
          m_fe   = stop ? 0 : 1;
          m_pe   = perr ? 1 : 0;
          m_oe   = 0;
        end else begin
          m_oe = 1;
        end
        check_status(tag);
      end
      @(negedge CLK);
    end
  endtask

  task automatic send_partial(input logic [7:0] data, input int nbits);
    align();
    for (int n = 0; n < (1 + nbits) * BITCLK; n++) begin
      if (n % BITCLK == 0) RXD = (n == 0) ? 1'b0 : data[n / BITCLK - 1];
      @(negedge CLK);
    end
  endtask

  task automatic host_read(input string tag);
    RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
    m_rdy = 0; m_fe = 0; m_pe = 0; m_oe = 0;
    check_status(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic pen, podd, pbit, stop, rdd;
    RST_N = 1'b0; CE = 1'b1; RXD = 1'b1; PAR_EN = 1'b0; PAR_ODD = 1'b0; RD = 1'b0;
    model_reset();
    #1;
    check_status("reset");
    check_eq("reset_busy", int'(BUSY), 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    send_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    host_read("a5_rd");

    align();
    for (int n = 0; n < 60; n++) begin
      if (n == 0) RXD = 1'b0;
      if (n == 12) RXD = 1'b1;
      if (n == 20) check_eq("glitch_busy", int'(BUSY), 1);
      if (n == 50) begin
        check_eq("glitch_idle", int'(BUSY), 0);
        check_eq("glitch_rdy", int'(RDY), 0);
      end
      @(negedge CLK);
    end
    send_frame("3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    host_read("3c_rd");

    send_frame("par_bad", 8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    host_read("par_bad_rd");
    send_frame("par_ok", 8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    host_read("par_ok_rd");
    send_frame("par_odd", 8'h37, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    host_read("par_odd_rd");

    send_frame("brk", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    host_read("brk_rd");
    for (int i = 0; i < 40; i++) begin
      repeat (BITCLK) @(negedge CLK);
      check_eq("brk_hold_rdy", int'(RDY), 0);
    end
    check_eq("brk_hold_busy", int'(BUSY), 1);
    RXD = 1'b1;
    repeat (8) @(negedge CLK);
    check_eq("brk_release_busy", int'(BUSY), 0);
    send_frame("5a", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    host_read("5a_rd");

    send_frame("ovr11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("ovr22", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("ovr33", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    send_partial(8'hFF, 4);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    check_status("async_rst");
    check_eq("async_rst_busy", int'(BUSY), 0);
    RXD = 1'b1;
    repeat (4) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    send_frame("81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_partial(8'h55, 3);
    CE = 1'b0;
    repeat (4) @(negedge CLK);
    RXD = 1'b1;
    repeat (BITCLK * 10) @(negedge CLK);
    check_eq("ce_busy", int'(BUSY), 0);
    check_status("ce_off");
    CE = 1'b1;
    repeat (4) @(negedge CLK);
    host_read("ce_rd");
    send_frame("ce_96", 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    host_read("ce_96_rd");

    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      pen  = ($urandom % 2) == 1;
      podd = ($urandom % 2) == 1;
      pbit = (^d) ^ podd ^ (($urandom % 4) == 0);
      stop = ($urandom % 5) != 0;
      rdd  = ($urandom % 3) == 0;
      send_frame("rnd", d, pen, podd, pbit, stop, rdd);
      if (!stop) begin
        RXD = 1'b1;
        repeat (8) @(negedge CLK);
      end
      if (($urandom % 2) == 1) host_read("rnd_rd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receive framer for the RX path. It consumes the oversampling tick produced by the RX baud generator and the raw serial line RXD. It detects and validates start bits, samples each bit at its centre, and assembles LSB-first data with optional parity. It presents a received byte with ready, framing, parity and overrun status to the host side.

## Interface
Parameters:
- OVERSAMPLE, 16: TICK pulses per bit period; must be even, 4..64.
- DATA_BITS, 8: data bits per frame, 5..8; DOUT upper unused bits read 0.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CE  input  1  receiver enable; low forces IDLE (synchronous), DOUT/status retained.
- TICK  input  1  oversampling strobe from the RX baud generator, one CLK wide per oversample period; ignored when CE=0.
- RXD  input  1  asynchronous serial input, idle high.
- PAR_EN  input  1  1 = parity bit follows data; sampled in IDLE only.
- PAR_ODD  input  1  1 = odd, 0 = even parity; sampled in IDLE only.
- RD  input  1  host read acknowledge, single-cycle; clears RDY/FE/PE/OE.
- DOUT  output  8  last accepted byte.
- RDY  output  1  DOUT holds an unread byte.
- FE  output  1  framing error (stop bit sampled 0) for the byte in DOUT.
- PE  output  1  parity error for the byte in DOUT.
- OE  output  1  overrun: a frame completed while RDY=1 and was discarded.
- BUSY  output  1  FSM not in IDLE.

## Operation
- RXD passes through a 2-FF synchronizer (reset value 1) before any use; rxd_s denotes the synchronized value.
- A tick counter (width clog2(OVERSAMPLE)) and a bit counter (width 3) advance only on TICK=1.
- IDLE: when rxd_s=0, go to START and clear tick counter. Latch PAR_EN/PAR_ODD on this entry.
- START: on the (OVERSAMPLE/2)th TICK, sample rxd_s. If 0, go to DATA and clear counters. If 1 (glitch), go to IDLE with no status change.
- DATA: every OVERSAMPLE TICKs, sample rxd_s into the shift register, LSB first. After DATA_BITS samples, go to PARITY if PAR_EN latched, else STOP.
- PARITY: after OVERSAMPLE TICKs, sample the parity bit. Error = XOR(data bits, parity bit, PAR_ODD) != 0.
- STOP: after OVERSAMPLE TICKs, sample the stop bit and complete the frame:
  - if RDY=0 or RD=1 this cycle: load DOUT, RDY=1, FE=!stop, PE=parity error (0 if parity disabled), OE=0.
  - if RDY=1 and RD=0: discard the frame; DOUT/FE/PE unchanged; OE=1.
  - next state is IDLE if stop=1, else BRK_WAIT.
- BRK_WAIT: hold until rxd_s=1, then go to IDLE. A held-low break yields exactly one frame.
- RD=1 with no completion in the same cycle clears RDY, FE, PE, OE next edge; DOUT holds.
- CE=0: next edge state=IDLE and counters cleared; the partial frame is dropped without status change.

## Timing
- Reset (RST_N=0, immediate): state IDLE, DOUT=0, RDY=FE=PE=OE=BUSY=0, sync FFs=1, counters 0.
- RXD falling edge to BUSY=1: 3 CLK (2 sync + 1 state).
- Samples fall at OVERSAMPLE/2 + k*OVERSAMPLE TICKs after start detection (bit centres).
- RDY/FE/PE/OE update on the CLK edge following the TICK that samples the stop bit. The FSM is IDLE/BRK_WAIT on the same edge, so back-to-back frames with 1 stop bit are received.
- BUSY is registered and reflects the current state.

## Test plan
- OVERSAMPLE=16, TICK every 4 CLK, no parity, frame 0xA5 → DOUT=0xA5, RDY=1, FE=PE=OE=0 one CLK after stop-centre TICK; RD → RDY=0, DOUT=0xA5 retained.
- RXD low for 3 TICKs then high → START aborts to IDLE, RDY stays 0, BUSY returns 0; following frame 0x3C is received correctly.
- PAR_EN=1, PAR_ODD=0, byte 0x37 with parity bit 0 (correct is 1) → DOUT=0x37, RDY=1, PE=1; repeat with parity bit 1 → PE=0.
- Frame 0x00 with stop bit 0, line then held low 40 bit times → one completion with FE=1, no further RDY events until RXD high. The next frame 0x5A is received with FE=0.
- Frames 0x11 then 0x22 back-to-back without RD → DOUT=0x11, OE=1. Third frame 0x33 with RD pulsed on its completion cycle → DOUT=0x33, RDY=1, OE=0.
- RST_N pulsed low mid-DATA of frame 0xFF → all outputs 0 immediately; a clean frame 0x81 after release → DOUT=0x81. CE dropped mid-frame → no RDY; the next frame is received after CE returns.
